// File: rtl/memory_test_noc_mux.sv
// memory_test_noc_mux
//
// NoC attach point shared by NUM_CH memory-tester engines and one router
// local port.
//
// Egress: whole messages are granted round-robin, and a credit counter
// converts the testers' val/rdy handshake into the router's credit/yummy
// protocol.
//
// Ingress: router flits are buffered in a small FIFO. Each message is then
// steered to the channel named in its header tag. Messages whose tag does
// not name a real channel are drained internally.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   ch_req_val/data per-channel egress flits (channel i at [i*W +: W])
//   ch_req_rdy      per-channel egress ready (one-hot on the grant)
//   mux_noc_val/data  flit to the router P input
//   noc_mux_yummy   router returned one input-buffer credit
//   noc_mux_val/data  flit from the router P output
//   mux_noc_yummy   one ingress FIFO slot freed (registered, cycle after pop)
//   ch_resp_val     per-channel ingress valid (at most one bit set)
//   ch_resp_data    ingress flit, shared by all channels
//   ch_resp_rdy     per-channel ingress ready
//   bad_tag         pulses on the pop of a header with tag >= NUM_CH
//   in_ovf_err      sticky: a flit arrived while the ingress FIFO was full

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 72
`endif

module memory_test_noc_mux #(
  parameter int NUM_CH      = 4,
  parameter int NOC_DATA_W  = `NOC_DATA_WIDTH,
  parameter int LEN_LSB     = 22,
  parameter int TAG_LSB     = 64,
  parameter int OUT_CREDITS = 4,
  parameter int IN_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_req_val,
  input  logic [NUM_CH*NOC_DATA_W-1:0] ch_req_data,
  output logic [NUM_CH-1:0]            ch_req_rdy,
  output logic                         mux_noc_val,
  output logic [NOC_DATA_W-1:0]        mux_noc_data,
  input  logic                         noc_mux_yummy,
  input  logic                         noc_mux_val,
  input  logic [NOC_DATA_W-1:0]        noc_mux_data,
  output logic                         mux_noc_yummy,
  output logic [NUM_CH-1:0]            ch_resp_val,
  output logic [NOC_DATA_W-1:0]        ch_resp_data,
  input  logic [NUM_CH-1:0]            ch_resp_rdy,
  output logic                         bad_tag,
  output logic                         in_ovf_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(IN_DEPTH);
  localparam logic [CH_W:0] NUM_CH_L   = (CH_W+1)'(NUM_CH);
  localparam logic [3:0]    CREDIT_MAX = 4'(OUT_CREDITS);
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(IN_DEPTH);

  typedef enum logic {EG_IDLE, EG_BODY} eg_state_t;
  typedef enum logic {IN_HDR, IN_BODY} in_state_t;

  // Wraps to channel 0 after the last real channel, which matters
  // when NUM_CH is not a power of two.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    if (int'(ch) >= NUM_CH - 1) return '0;
    return ch + 1'b1;
  endfunction

  // ---------------------------------------------------------------- egress
  eg_state_t        eg_state, eg_state_nxt;
  logic [CH_W-1:0]  grant_q, grant_nxt, rr_ptr, rr_ptr_nxt;
  logic [CH_W-1:0]  arb_grant, sel_ch;
  logic [7:0]       body_cnt, body_cnt_nxt, hdr_len;
  logic [3:0]       credit_cnt, credit_nxt;
  logic             arb_found, sel_val, has_credit, eg_xfer;
  logic [NOC_DATA_W-1:0] sel_data;

  // Round-robin search starting at rr_ptr. It only matters in IDLE,
  // because a message in BODY stays locked to its latched channel.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!arb_found && ch_req_val[(int'(rr_ptr) + k) % NUM_CH]) begin
        arb_found = 1'b1;
        arb_grant = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  // Egress datapath, handshake and next-state logic.
  // A flit moves only when the served channel is valid and a router
  // credit is available.
  always_comb begin
    sel_ch       = (eg_state == EG_BODY) ? grant_q : arb_grant;
    sel_val      = (eg_state == EG_BODY) ? ch_req_val[sel_ch] : arb_found;
    has_credit   = (credit_cnt != 4'd0);
    eg_xfer      = sel_val && has_credit;
    sel_data     = ch_req_data[int'(sel_ch)*NOC_DATA_W +: NOC_DATA_W];
    hdr_len      = sel_data[LEN_LSB +: 8];
    mux_noc_val  = eg_xfer;
    mux_noc_data = sel_data;
    ch_req_rdy   = '0;
    if (eg_xfer) ch_req_rdy[sel_ch] = 1'b1;

    eg_state_nxt = eg_state;
    grant_nxt    = grant_q;
    rr_ptr_nxt   = rr_ptr;
    body_cnt_nxt = body_cnt;
    if (eg_xfer) begin
      case (eg_state)
        EG_IDLE: begin
          if (hdr_len == 8'd0) begin
            rr_ptr_nxt = next_ch(arb_grant);
          end else begin
            body_cnt_nxt = hdr_len;
            grant_nxt    = arb_grant;
            eg_state_nxt = EG_BODY;
          end
        end
        EG_BODY: begin
          body_cnt_nxt = body_cnt - 8'd1;
          if (body_cnt == 8'd1) begin
            eg_state_nxt = EG_IDLE;
            rr_ptr_nxt   = next_ch(grant_q);
          end
        end
        default: eg_state_nxt = EG_IDLE;
      endcase
    end

    // If a send and a yummy land in the same cycle, the count does not change.
    // A yummy that arrives while the counter is already full is ignored.
    credit_nxt = credit_cnt;
    if (eg_xfer && !noc_mux_yummy)
      credit_nxt = credit_cnt - 4'd1;
    else if (!eg_xfer && noc_mux_yummy && credit_cnt < CREDIT_MAX)
      credit_nxt = credit_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      eg_state   <= EG_IDLE;
      grant_q    <= '0;
      rr_ptr     <= '0;
      body_cnt   <= '0;
      credit_cnt <= CREDIT_MAX;
    end else begin
      eg_state   <= eg_state_nxt;
      grant_q    <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      body_cnt   <= body_cnt_nxt;
      credit_cnt <= credit_nxt;
    end
  end

  // --------------------------------------------------------------- ingress
  logic [NOC_DATA_W-1:0] fifo_mem [IN_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic            fifo_full, fifo_empty, fifo_wr, in_pop;
  logic [NOC_DATA_W-1:0] head;
  logic [CH_W-1:0] head_tag, route_ch, cur_ch;
  logic [7:0]      head_len, rem_cnt;
  logic            head_bad, route_bad, cur_bad, route_rdy, yummy_q, ovf_q;
  in_state_t       in_state;

  // Steering decode. While in HDR, the route comes straight from the head
  // flit. While in BODY, it comes from the channel latched at the header pop.
  // Fullness is judged before any pop in the same cycle, so a write into a
  // full FIFO is dropped even when a pop happens together with it.
  always_comb begin
    fifo_full  = (fifo_cnt == DEPTH_L);
    fifo_empty = (fifo_cnt == '0);
    fifo_wr    = noc_mux_val && !fifo_full;
    head       = fifo_mem[rd_ptr];
    head_tag   = head[TAG_LSB +: CH_W];
    head_len   = head[LEN_LSB +: 8];
    head_bad   = ({1'b0, head_tag} >= NUM_CH_L);
    route_ch   = (in_state == IN_HDR) ? head_tag : cur_ch;
    route_bad  = (in_state == IN_HDR) ? head_bad : cur_bad;
    route_rdy  = 1'b0;
    ch_resp_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (route_ch == CH_W'(i)) begin
        route_rdy      = ch_resp_rdy[i];
        ch_resp_val[i] = !fifo_empty && !route_bad;
      end
    end
    in_pop       = !fifo_empty && (route_bad || route_rdy);
    bad_tag      = in_pop && (in_state == IN_HDR) && head_bad;
    ch_resp_data = head;
  end

  // FIFO storage. It has no reset because occupancy is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= noc_mux_data;
  end

  // FIFO pointers, the steering FSM, the registered yummy and the sticky
  // overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      in_state <= IN_HDR;
      cur_ch   <= '0;
      cur_bad  <= 1'b0;
      rem_cnt  <= '0;
      yummy_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (in_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_wr && !in_pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!fifo_wr && in_pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (in_pop) begin
        if (in_state == IN_HDR) begin
          if (head_len != 8'd0) begin
            in_state <= IN_BODY;
            cur_ch   <= head_tag;
            cur_bad  <= head_bad;
            rem_cnt  <= head_len;
          end
        end else begin
          rem_cnt <= rem_cnt - 8'd1;
          if (rem_cnt == 8'd1) in_state <= IN_HDR;
        end
      end
      yummy_q <= in_pop;
      if (noc_mux_val && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign mux_noc_yummy = yummy_q;
  assign in_ovf_err    = ovf_q;

endmodule

// File: tb/tb_memory_test_noc_mux.sv
// Testbench for memory_test_noc_mux.
// The main instance uses NUM_CH=4. A second instance uses NUM_CH=3, so that
// tag 3 is an invalid tag for the bad-tag check.
module tb_memory_test_noc_mux;

  localparam int NCH = 4, W = 72, LEN_LSB = 22, TAG_LSB = 64;
  localparam int OUTC = 4, DEPTH = 4;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]   ch_req_val, ch_req_rdy, ch_resp_val, ch_resp_rdy;
  logic [NCH*W-1:0] ch_req_data;
  logic             mux_noc_val, noc_mux_yummy, noc_mux_val, mux_noc_yummy;
  logic             bad_tag, in_ovf_err;
  logic [W-1:0]     mux_noc_data, noc_mux_data, ch_resp_data;

  logic [2:0]   b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
  logic [3*W-1:0] b_req_data;
  logic         b_noc_val, b_yummy_in, b_val_in, b_yummy_out, b_bad_tag, b_ovf;
  logic [W-1:0] b_noc_data, b_data_in, b_resp_data;

  memory_test_noc_mux #(.NUM_CH(NCH), .NOC_DATA_W(W), .LEN_LSB(LEN_LSB),
    .TAG_LSB(TAG_LSB), .OUT_CREDITS(OUTC), .IN_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ch_req_val(ch_req_val), .ch_req_data(ch_req_data),
    .ch_req_rdy(ch_req_rdy), .mux_noc_val(mux_noc_val), .mux_noc_data(mux_noc_data),
    .noc_mux_yummy(noc_mux_yummy), .noc_mux_val(noc_mux_val),
    .noc_mux_data(noc_mux_data), .mux_noc_yummy(mux_noc_yummy),
    .ch_resp_val(ch_resp_val), .ch_resp_data(ch_resp_data),
    .ch_resp_rdy(ch_resp_rdy), .bad_tag(bad_tag), .in_ovf_err(in_ovf_err));

  memory_test_noc_mux #(.NUM_CH(3), .NOC_DATA_W(W), .LEN_LSB(LEN_LSB),
    .TAG_LSB(TAG_LSB), .OUT_CREDITS(OUTC), .IN_DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .ch_req_val(b_req_val), .ch_req_data(b_req_data),
    .ch_req_rdy(b_req_rdy), .mux_noc_val(b_noc_val), .mux_noc_data(b_noc_data),
    .noc_mux_yummy(b_yummy_in), .noc_mux_val(b_val_in),
    .noc_mux_data(b_data_in), .mux_noc_yummy(b_yummy_out),
    .ch_resp_val(b_resp_val), .ch_resp_data(b_resp_data),
    .ch_resp_rdy(b_resp_rdy), .bad_tag(b_bad_tag), .in_ovf_err(b_ovf));

  int num_checks = 0, num_errors = 0;

  // Egress scoreboard: per-channel tester queues, plus the expected order of
  // flits onto the router.
  logic [W-1:0] chq [NCH][$];
  logic [W-1:0] eg_sb [$];
  int credit;

  // Ingress reference: FIFO contents and steering state.
  logic [W-1:0] mq [$];
  bit m_hdr, m_bad, m_ovf, m_pop_prev;
  int m_cur, m_rem;

  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [W-1:0] eg_flit(input int ch, input int seq, input int len);
    logic [W-1:0] f;
    f = '0;
    f[7:0] = 8'(seq);
    f[15:8] = 8'(ch);
    f[LEN_LSB +: 8] = 8'(len);
    f[63:40] = 24'h5A5A00 ^ 24'(seq * 7);
    return f;
  endfunction

  function automatic logic [W-1:0] in_flit(input int tag, input int len, input int seq);
    logic [W-1:0] f;
    f = '0;
    f[7:0] = 8'(seq);
    f[LEN_LSB +: 8] = 8'(len);
    f[TAG_LSB +: 2] = 2'(tag);
    f[71:66] = 6'(seq + 13);
    return f;
  endfunction

  // Body flits carry junk in the tag and length fields. The DUT must not
  // reinterpret them as a header.
  function automatic logic [W-1:0] in_body(input int seq);
    logic [W-1:0] f;
    f = in_flit(1, 8'h33, seq);
    return f;
  endfunction

  // Queues one whole message on channel ch. Calls to this task must follow
  // the order in which the arbiter is expected to serve the messages.
  task automatic pushMsg(input int ch, input int len);
    logic [W-1:0] f;
    for (int j = 0; j <= len; j++) begin
      f = eg_flit(ch, ch * 16 + j, (j == 0) ? len : 8'hA5);
      chq[ch].push_back(f);
      eg_sb.push_back(f);
    end
  endtask

  // Runs one clock cycle on the main DUT: drives the inputs, checks both
  // directions, and advances the reference state.
  task automatic applyStimulus(input logic y, input logic iv,
                               input logic [W-1:0] idata, input logic [NCH-1:0] rdy);
    bit pending, exp_val, full, pop, hb;
    logic [NCH-1:0] exp_rdy, exp_rv;
    logic [W-1:0] hd;
    int ch, hlen;
    for (int i = 0; i < NCH; i++) begin
      ch_req_val[i] = (chq[i].size() > 0);
      ch_req_data[i*W +: W] = (chq[i].size() > 0) ? chq[i][0] : '0;
    end
    noc_mux_yummy = y;
    noc_mux_val = iv;
    noc_mux_data = idata;
    ch_resp_rdy = rdy;
    @(negedge clk);
    pending = 0;
    for (int i = 0; i < NCH; i++) if (chq[i].size() > 0) pending = 1;
    exp_val = pending && (credit > 0);
    checkOutput("eg_val", mux_noc_val, exp_val);
    exp_rdy = '0;
    if (exp_val && eg_sb.size() > 0) exp_rdy[int'(eg_sb[0][15:8])] = 1'b1;
    checkOutput("eg_rdy", ch_req_rdy, exp_rdy);
    if (mux_noc_val) begin
      if (eg_sb.size() == 0) checkOutput("eg_spurious", mux_noc_val, 1'b0);
      else checkOutput("eg_data", mux_noc_data, eg_sb.pop_front());
    end
    for (int i = 0; i < NCH; i++)
      if (ch_req_val[i] && ch_req_rdy[i]) void'(chq[i].pop_front());
    if (exp_val && !y) credit--;
    else if (!exp_val && y && credit < OUTC) credit++;

    exp_rv = '0;
    pop = 0;
    hb = 0;
    hd = '0;
    hlen = 0;
    if (mq.size() > 0) begin
      hd = mq[0];
      hlen = int'(hd[LEN_LSB +: 8]);
      ch = m_hdr ? int'(hd[TAG_LSB +: 2]) : m_cur;
      hb = m_hdr ? (ch >= NCH) : m_bad;
      if (!hb) exp_rv[ch] = 1'b1;
      pop = hb || rdy[ch];
    end
    checkOutput("resp_val", ch_resp_val, exp_rv);
    if (exp_rv != '0) checkOutput("resp_data", ch_resp_data, hd);
    checkOutput("bad_tag", bad_tag, pop && m_hdr && hb);
    checkOutput("yummy", mux_noc_yummy, m_pop_prev);
    checkOutput("ovf", in_ovf_err, m_ovf);
    full = (mq.size() == DEPTH);
    if (pop) begin
      void'(mq.pop_front());
      if (m_hdr) begin
        if (hlen != 0) begin
          m_hdr = 0; m_cur = ch; m_bad = hb; m_rem = hlen;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_hdr = 1;
      end
    end
    if (iv) begin
      if (full) m_ovf = 1;
      else mq.push_back(idata);
    end
    m_pop_prev = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic egStep(input logic y);
    applyStimulus(y, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    ch_req_val = '0; ch_req_data = '0; noc_mux_yummy = 0; noc_mux_val = 0;
    noc_mux_data = '0; ch_resp_rdy = '0;
    b_req_val = '0; b_req_data = '0; b_yummy_in = 0; b_val_in = 0;
    b_data_in = '0; b_resp_rdy = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) chq[i].delete();
    eg_sb.delete(); mq.delete();
    credit = OUTC; m_hdr = 1; m_bad = 0; m_ovf = 0; m_pop_prev = 0; m_cur = 0; m_rem = 0;
    @(negedge clk);
    checkOutput("rst_eg_val", mux_noc_val, 1'b0);
    checkOutput("rst_req_rdy", ch_req_rdy, '0);
    checkOutput("rst_yummy", mux_noc_yummy, 1'b0);
    checkOutput("rst_resp_val", ch_resp_val, '0);
    checkOutput("rst_bad_tag", bad_tag, 1'b0);
    checkOutput("rst_ovf", in_ovf_err, 1'b0);
    checkOutput("rst_b_resp_val", b_resp_val, '0);
    checkOutput("rst_b_ovf", b_ovf, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_cnt, yum_cnt, good_cnt, wrong_cnt;
    logic [W-1:0] good;
    doReset();

    // One channel sends a message; then a credit-limited two-way offer
    // checks where rr_ptr ended up.
    pushMsg(1, 2);
    repeat (5) egStep(1'b0);
    pushMsg(2, 0);
    pushMsg(0, 0);
    repeat (3) egStep(1'b0);
    egStep(1'b1);
    repeat (2) egStep(1'b0);
    repeat (4) egStep(1'b1);

    // Arbitration between competing channels; the second round is a
    // three-way offer.
    doReset();
    pushMsg(0, 1);
    pushMsg(2, 1);
    repeat (5) egStep(1'b0);
    repeat (4) egStep(1'b1);
    pushMsg(0, 0);
    pushMsg(1, 0);
    pushMsg(2, 0);
    repeat (4) egStep(1'b0);

    // Credit stall, then credits returned one at a time, then transfers with
    // a yummy in the same cycle.
    doReset();
    pushMsg(3, 5);
    repeat (8) egStep(1'b0);
    egStep(1'b1);
    egStep(1'b0);
    egStep(1'b1);
    egStep(1'b0);
    repeat (2) egStep(1'b1);
    pushMsg(0, 2);
    repeat (5) egStep(1'b1);

    // Ingress steering under backpressure, then the write-to-visible latency.
    doReset();
    applyStimulus(1'b0, 1'b1, in_flit(3, 2, 1), 4'b0000);
    applyStimulus(1'b0, 1'b1, in_body(2), 4'b0000);
    applyStimulus(1'b0, 1'b1, in_body(3), 4'b0000);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 4'b0000);
    repeat (5) applyStimulus(1'b0, 1'b0, '0, 4'b1000);
    applyStimulus(1'b0, 1'b1, in_flit(1, 0, 4), 4'b1111);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 4'b1111);

    // Overflow with the FIFO held full, then overflow on a write that comes
    // in the same cycle as a pop.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, in_flit(0, 0, 16 + i), 4'b0000);
    applyStimulus(1'b0, 1'b0, '0, 4'b0000);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, in_flit(0, 0, 32 + i), 4'b0000);
    applyStimulus(1'b0, 1'b1, in_flit(0, 0, 40), 4'b1111);
    repeat (5) applyStimulus(1'b0, 1'b0, '0, 4'b1111);
    doReset();

    // Bad tag on the three-channel instance, followed by a valid message.
    bad_cnt = 0; yum_cnt = 0; good_cnt = 0; wrong_cnt = 0;
    good = in_flit(2, 0, 9);
    b_resp_rdy = 3'b111;
    for (int c = 0; c < 10; c++) begin
      b_val_in = (c < 3);
      b_data_in = (c == 0) ? in_flit(3, 1, 7) : (c == 1) ? in_body(8) : (c == 2) ? good : '0;
      @(negedge clk);
      if (b_bad_tag) bad_cnt++;
      if (b_yummy_out) yum_cnt++;
      if (b_resp_val != '0) begin
        if (b_resp_val == 3'b100 && b_resp_data == good) good_cnt++;
        else wrong_cnt++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("b_bad_tag_pulses", 72'(bad_cnt), 72'd1);
    checkOutput("b_yummies", 72'(yum_cnt), 72'd3);
    checkOutput("b_good_deliveries", 72'(good_cnt), 72'd1);
    checkOutput("b_wrong_deliveries", 72'(wrong_cnt), 72'd0);
    checkOutput("b_ovf", b_ovf, 1'b0);

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
